// File: rtl/spi_master_ctrl.sv
// SPI master with configurable word width, clock divider and chip-select count.
// CPOL/CPHA and bit order are latched per transfer; MISO is captured full-duplex.
module spi_master_ctrl #(
   parameter int  DW      = 12,
   parameter int  CLK_DIV = 10,
   parameter int  NUM_CS  = 1,
   localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   // Handshake: a transfer is accepted on a rising clk edge where start && ready;
   // start while busy is dropped, never queued. done pulses once per accepted word.
   input  logic              start,
   output logic              ready,
   input  logic [DW-1:0]     din,
   input  logic [CSW-1:0]    cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic              miso,
   output logic              sclk,
   output logic [NUM_CS-1:0] cs_n,
   output logic              mosi,
   output logic [DW-1:0]     dout,
   output logic              done,
   output logic              busy,
   output logic              dbg_state_o
);

   localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EW  = $clog2(2 * DW + 1);
   localparam int IW  = $clog2(DW);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [DCW-1:0]      div_q, div_d;
   logic [EW-1:0]       edge_q, edge_d;
   logic                sclk_q, sclk_d;
   logic                mosi_q, mosi_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic [DW-1:0]       dout_q, dout_d;
   logic                done_q, done_d;
   logic [DW-1:0]       tx_q, tx_d;
   logic [DW-1:0]       rx_q, rx_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic                lsb_q, lsb_d;

   logic [NUM_CS-1:0]   cs_dec;
   logic                tick;
   logic [EW-1:0]       edge_n;
   logic [IW-1:0]       idx, rx_idx, tx_pos, rx_pos;

   always_comb begin
      cs_dec = '1;
      for (int j = 0; j < NUM_CS; j++) begin
         if (cs_sel == CSW'(j)) cs_dec[j] = 1'b0;
      end
   end

   // edge_n is the number of the sclk edge being registered this cycle; edge k
   // carries bit index k>>1 for mosi, and the receive index lags by one on trailing edges.
   always_comb begin
      tick   = (div_q == DCW'(CLK_DIV - 1));
      edge_n = edge_q + EW'(1);
      idx    = edge_n[IW:1];
      rx_idx = edge_n[0] ? idx : idx - IW'(1);
      tx_pos = lsb_q ? idx : IW'(DW - 1) - idx;
      rx_pos = lsb_q ? rx_idx : IW'(DW - 1) - rx_idx;
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      edge_d  = edge_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      lsb_d   = lsb_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACTIVE;
               div_d   = '0;
               edge_d  = '0;
               tx_d    = din;
               rx_d    = '0;
               cpol_d  = cpol;
               cpha_d  = cpha;
               lsb_d   = lsb_first;
               sclk_d  = cpol;
               cs_n_d  = cs_dec;
               mosi_d  = cpha ? 1'b0 : (lsb_first ? din[0] : din[DW-1]);
            end
         end
         ACTIVE: begin
            if (!tick) begin
               div_d = div_q + DCW'(1);
            end else begin
               div_d = '0;
               if (edge_q == EW'(2 * DW)) begin
                  // Final half-period elapsed: release the bus and publish the word.
                  state_d = IDLE;
                  edge_d  = '0;
                  cs_n_d  = '1;
                  sclk_d  = cpol_q;
                  mosi_d  = 1'b0;
                  dout_d  = rx_q;
                  done_d  = 1'b1;
               end else begin
                  edge_d = edge_n;
                  sclk_d = ~sclk_q;
                  if (edge_n[0]) begin
                     if (cpha_q) mosi_d = tx_q[tx_pos];
                     else        rx_d[rx_pos] = miso;
                  end else begin
                     if (cpha_q)                          rx_d[rx_pos] = miso;
                     else if (edge_n != EW'(2 * DW))      mosi_d = tx_q[tx_pos];
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            cs_n_d  = '1;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= '1;
         dout_q  <= '0;
         done_q  <= 1'b0;
         tx_q    <= '0;
         rx_q    <= '0;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         lsb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         lsb_q   <= lsb_d;
      end
   end

   assign ready       = (state_q == IDLE);
   assign busy        = ~ready;
   assign sclk        = sclk_q;
   assign mosi        = mosi_q;
   assign cs_n        = cs_n_q;
   assign dout        = dout_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: three instances (DW=8/CLK_DIV=2/5 CS, DW=2/CLK_DIV=1,
// default DW=12/CLK_DIV=10) driven sequentially, results checked against expected queues.
module tb_spi_master_ctrl;

   localparam int DWA = 8;
   localparam int CDA = 2;
   localparam int NCA = 5;
   localparam int DWB = 2;
   localparam int CDB = 1;
   localparam int DWC = 12;
   localparam int CDC = 10;
   localparam int LIM = 2000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- instance A ----------------
   logic           rst_a, start_a, cpol_a, cpha_a, lsb_a, inv_a, miso_a;
   logic           sclk_a, mosi_a, done_a, busy_a, ready_a, dbg_a;
   logic [DWA-1:0] din_a, dout_a;
   logic [2:0]     sel_a;
   logic [NCA-1:0] cs_n_a;
   assign miso_a = mosi_a ^ inv_a;

   spi_master_ctrl #(.DW(DWA), .CLK_DIV(CDA), .NUM_CS(NCA)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a), .ready(ready_a), .din(din_a),
      .cs_sel(sel_a), .cpol(cpol_a), .cpha(cpha_a), .lsb_first(lsb_a), .miso(miso_a),
      .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .dout(dout_a), .done(done_a),
      .busy(busy_a), .dbg_state_o(dbg_a));

   // ---------------- instance B ----------------
   logic           rst_b, start_b, cpol_b, cpha_b, lsb_b, inv_b, miso_b;
   logic           sclk_b, mosi_b, done_b, busy_b, ready_b, dbg_b;
   logic [DWB-1:0] din_b, dout_b;
   logic [0:0]     sel_b, cs_n_b;
   assign miso_b = mosi_b ^ inv_b;

   spi_master_ctrl #(.DW(DWB), .CLK_DIV(CDB), .NUM_CS(1)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .ready(ready_b), .din(din_b),
      .cs_sel(sel_b), .cpol(cpol_b), .cpha(cpha_b), .lsb_first(lsb_b), .miso(miso_b),
      .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .dout(dout_b), .done(done_b),
      .busy(busy_b), .dbg_state_o(dbg_b));

   // ---------------- instance C ----------------
   logic           rst_c, start_c, cpol_c, cpha_c, lsb_c, miso_c;
   logic           sclk_c, mosi_c, done_c, busy_c, ready_c, dbg_c;
   logic [DWC-1:0] din_c, dout_c;
   logic [0:0]     sel_c, cs_n_c;
   assign miso_c = mosi_c;

   spi_master_ctrl #(.DW(DWC), .CLK_DIV(CDC), .NUM_CS(1)) dut_c (
      .clk(clk), .rst(rst_c), .start(start_c), .ready(ready_c), .din(din_c),
      .cs_sel(sel_c), .cpol(cpol_c), .cpha(cpha_c), .lsb_first(lsb_c), .miso(miso_c),
      .sclk(sclk_c), .cs_n(cs_n_c), .mosi(mosi_c), .dout(dout_c), .done(done_c),
      .busy(busy_c), .dbg_state_o(dbg_c));

   // ---------------- scoreboard for A ----------------
   logic [DWA-1:0] exp_dout_q[$];
   logic [DWA-1:0] exp_seq_q[$];
   logic [NCA-1:0] exp_cs_q[$];
   int             acc_cyc_q[$];
   logic [DWB-1:0] exp_b_q[$];

   function automatic logic [DWA-1:0] rev_a(input logic [DWA-1:0] v);
      for (int i = 0; i < DWA; i++) rev_a[i] = v[DWA-1-i];
   endfunction

   function automatic logic [NCA-1:0] cs_mask(input logic [2:0] s);
      cs_mask = '0;
      if (int'(s) < NCA) cs_mask[s] = 1'b1;
   endfunction

   initial begin : mon_a
      int             nbusy, nedge, gap, badgap;
      logic [DWA-1:0] seq;
      logic [NCA-1:0] seen;
      logic           psclk, pbusy, pdone, lcpha;
      nbusy = 0; nedge = 0; gap = 0; badgap = 0; seq = '0; seen = '0;
      psclk = 1'b0; pbusy = 1'b0; pdone = 1'b0; lcpha = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_a) begin
            pbusy = 1'b0; pdone = 1'b0; psclk = sclk_a;
            continue;
         end
         if (busy_a) begin
            nbusy++;
            seen = seen | ~cs_n_a;
            if (pbusy && sclk_a != psclk) begin
               nedge++;
               if (gap != CDA) badgap++;
               gap = 0;
               if (nedge[0] != lcpha) seq = {seq[DWA-2:0], mosi_a};
            end
            gap++;
         end
         if (done_a) begin
            check("a_done_single", pdone, 1'b0);
            check("a_pending", exp_dout_q.size(), 1);
            check("a_cs_idle_at_end", cs_n_a, {NCA{1'b1}});
            check("a_ready_at_end", ready_a, 1'b1);
            check("a_edges", nedge, 2 * DWA);
            check("a_cs_low_cycles", nbusy, (2 * DWA + 1) * CDA);
            check("a_halfperiod", badgap, 0);
            if (exp_dout_q.size() != 0) begin
               check("a_dout", dout_a, exp_dout_q.pop_front());
               check("a_mosi_seq", seq, exp_seq_q.pop_front());
               check("a_cs_mask", seen, exp_cs_q.pop_front());
            end
         end
         if (ready_a && start_a) begin
            exp_dout_q.push_back(din_a ^ {DWA{inv_a}});
            exp_seq_q.push_back(lsb_a ? rev_a(din_a) : din_a);
            exp_cs_q.push_back(cs_mask(sel_a));
            acc_cyc_q.push_back(cyc);
            lcpha = cpha_a;
            nbusy = 0; nedge = 0; gap = 0; badgap = 0; seq = '0; seen = '0;
         end
         psclk = sclk_a;
         pbusy = busy_a;
         pdone = done_a;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue_a(input logic [DWA-1:0] d, input logic [2:0] s,
                          input logic pol, input logic pha, input logic lsb, input logic inv);
      int n = 0;
      while (!ready_a && n < LIM) begin @(posedge clk); #1; n++; end
      check("a_ready_timeout", n < LIM, 1'b1);
      din_a = d; sel_a = s; cpol_a = pol; cpha_a = pha; lsb_a = lsb; inv_a = inv;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while ((!ready_a || exp_dout_q.size() != 0) && n < LIM) begin @(posedge clk); #1; n++; end
      check("a_idle_timeout", n < LIM, 1'b1);
   endtask

   task automatic xfer_b(input logic [DWB-1:0] d, input logic pol, input logic pha,
                         input logic lsb, input logic inv);
      int   n, low, tog;
      logic ps;
      din_b = d; cpol_b = pol; cpha_b = pha; lsb_b = lsb; inv_b = inv;
      start_b = 1'b1;
      exp_b_q.push_back(d ^ {DWB{inv}});
      @(posedge clk); #1;
      start_b = 1'b0;
      n = 0; low = 0; tog = 0; ps = sclk_b;
      while (!done_b && n < 50) begin
         if (cs_n_b == 1'b0) low++;
         if (sclk_b != ps) tog++;
         ps = sclk_b;
         @(posedge clk); #1;
         n++;
      end
      check("b_done_seen", done_b, 1'b1);
      check("b_cs_low", low, (2 * DWB + 1) * CDB);
      check("b_sclk_toggles", tog, 2 * DWB);
      check("b_dout", dout_b, exp_b_q.pop_front());
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int   n, tog, ndone;
      logic ps;
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      din_a = '0; din_b = '0; din_c = '0;
      sel_a = '0; sel_b = '0; sel_c = '0;
      cpol_a = 0; cpha_a = 0; lsb_a = 0; inv_a = 0;
      cpol_b = 0; cpha_b = 0; lsb_b = 0; inv_b = 0;
      cpol_c = 0; cpha_c = 0; lsb_c = 0;
      repeat (3) @(posedge clk);
      #1;
      check("a_reset_ctrl", {ready_a, busy_a, done_a, sclk_a, mosi_a}, 5'b10000);
      check("a_reset_cs_n", cs_n_a, {NCA{1'b1}});
      check("a_reset_dout", dout_a, 0);
      check("c_reset_ctrl", {ready_c, busy_c, done_c, sclk_c, mosi_c, cs_n_c}, 6'b100001);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

      // mode 0, MSB-first loopback, then mode 3, LSB-first with inverted slave data
      issue_a(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_idle_a();
      check("a_sclk_idle_mode0", sclk_a, 1'b0);
      issue_a(8'h3C, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_idle_a();
      check("a_sclk_idle_mode3", sclk_a, 1'b1);

      // chip-select targeting: back-to-back 2 then 3, then an out-of-range select
      issue_a(8'($urandom_range(0, 255)), 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      issue_a(8'($urandom_range(0, 255)), 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
      wait_idle_a();
      issue_a(8'($urandom_range(0, 255)), 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_idle_a();

      for (int k = 0; k < 6; k++) begin
         issue_a(8'($urandom_range(0, 255)), 3'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_idle_a();

      // start held across a transfer with din changed mid-way
      acc_cyc_q.delete();
      din_a = 8'h5A; sel_a = 3'd1; cpol_a = 0; cpha_a = 0; lsb_a = 0; inv_a = 0;
      start_a = 1'b1;
      n = 0;
      while (acc_cyc_q.size() < 1 && n < LIM) begin @(posedge clk); #1; n++; end
      repeat (10) @(posedge clk);
      #1;
      din_a = 8'h99;
      n = 0;
      while (acc_cyc_q.size() < 2 && n < LIM) begin @(posedge clk); #1; n++; end
      start_a = 1'b0;
      check("a_hold_accepts", acc_cyc_q.size(), 2);
      if (acc_cyc_q.size() == 2)
         check("a_hold_spacing", acc_cyc_q[1] - acc_cyc_q[0], (2 * DWA + 1) * CDA + 1);
      wait_idle_a();

      // DW=2, CLK_DIV=1: every pattern, mode and bit order
      for (int p = 0; p < 4; p++)
         for (int m = 0; m < 4; m++)
            for (int l = 0; l < 2; l++)
               xfer_b(2'(p), m[1], m[0], l[0], 1'($urandom_range(0, 1)));

      // default-size instance: one full transfer, then reset at sclk edge 5
      din_c = 12'hA5C; cpol_c = 0; cpha_c = 1; lsb_c = 1;
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      n = 0;
      while (!done_c && n < LIM) begin @(posedge clk); #1; n++; end
      check("c_done", done_c, 1'b1);
      check("c_dout", dout_c, 12'hA5C);
      din_c = 12'h3F1; cpol_c = 0; cpha_c = 0; lsb_c = 0;
      start_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      n = 0; tog = 0; ps = sclk_c; ndone = 0;
      while (tog < 5 && n < LIM) begin
         @(posedge clk); #1;
         n++;
         if (done_c) ndone++;
         if (sclk_c != ps) tog++;
         ps = sclk_c;
      end
      check("c_edges_before_rst", tog, 5);
      rst_c = 1'b1;
      @(posedge clk); #1;
      check("c_rst_cs_n", cs_n_c, 1'b1);
      check("c_rst_sclk", sclk_c, 1'b0);
      check("c_rst_mosi", mosi_c, 1'b0);
      check("c_rst_ready", ready_c, 1'b1);
      check("c_rst_dout", dout_c, 0);
      rst_c = 1'b0;
      repeat (300) begin
         @(posedge clk); #1;
         if (done_c) ndone++;
      end
      check("c_no_done_after_rst", ndone, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
